// File: rtl/sd_dat_block_tx_pkg.sv
// Shared SD data-path definitions: CRC16 constants, line start/end bit levels,
// block transmitter FSM encoding, and the byte-parallel CRC16 step function
// that the upstream CRC16 stage also uses.
package sd_dat_block_tx_pkg;

  localparam logic [15:0] Crc16Poly = 16'h1021;
  localparam logic [15:0] Crc16Init = 16'h0000;
  localparam logic        StartBit  = 1'b0;
  localparam logic        EndBit    = 1'b1;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StCrc,
    StEnd
  } sd_tx_state_e;

  // CRC-16/XMODEM advanced by one byte, MSB first, no reflection.
  function automatic logic [15:0] nextCRC16_D8(input logic [15:0] crc, input logic [7:0] data);
    logic [15:0] c;
    logic        fb;
    c = crc;
    for (int i = 7; i >= 0; i--) begin
      fb = c[15] ^ data[i];
      c  = {c[14:0], 1'b0};
      if (fb) c = c ^ Crc16Poly;
    end
    return c;
  endfunction

endpackage

// File: rtl/sd_dat_block_tx_if.sv
// Payload byte stream (valid/ready) into the SD block transmitter.
//   data  : payload byte
//   valid : data valid (producer)
//   ready : byte taken on a clk edge with valid & ready (consumer)
interface sd_dat_block_tx_if;
  logic [7:0] data;
  logic       valid;
  logic       ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/sd_dat_block_tx_crc16_acc.sv
// Byte-parallel CRC16 accumulator with synchronous clear and enable.
//   clk, rst_n : clock, async active-low reset
//   clr        : reload the init value (wins over en)
//   en         : fold data into the running CRC
//   data       : byte to fold
//   crc        : current CRC value
module sd_dat_block_tx_crc16_acc
  import sd_dat_block_tx_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        en,
  input  logic [7:0]  data,
  output logic [15:0] crc
);

  logic [15:0] crc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_q <= Crc16Init;
    end else if (clr) begin
      crc_q <= Crc16Init;
    end else if (en) begin
      crc_q <= nextCRC16_D8(crc_q, data);
    end
  end

  assign crc = crc_q;

endmodule

// File: rtl/sd_dat_block_tx.sv
// SD 1-bit DAT0 block transmitter: start bit, BLOCK_BYTES payload bytes MSB
// first, CRC16 of the payload, end bit; one line bit per bit_en tick.
//   clk, rst_n : clock, async active-low reset
//   start      : request a block (only honoured while idle)
//   bit_en     : SD bit-time strobe
//   in_if      : payload byte stream (slave side)
//   sd_dat     : DAT0 line value
//   sd_dat_oe  : DAT0 output enable
//   hold       : payload underrun, SD_CLK must be stopped while high
//   busy       : block in progress
//   done       : one-cycle pulse after the end bit
module sd_dat_block_tx
  import sd_dat_block_tx_pkg::*;
#(
  parameter int unsigned BLOCK_BYTES = 512,
  parameter int unsigned CNT_W       = 13
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 bit_en,
  sd_dat_block_tx_if.slave     in_if,
  output logic                 sd_dat,
  output logic                 sd_dat_oe,
  output logic                 hold,
  output logic                 busy,
  output logic                 done
);

  localparam logic [CNT_W-1:0] LastBit = CNT_W'(8 * BLOCK_BYTES - 1);
  localparam logic [CNT_W-1:0] ByteMax = CNT_W'(BLOCK_BYTES);

  sd_tx_state_e     state_q, state_d;
  logic [7:0]       pf_q, pf_d;
  logic             pf_full_q, pf_full_d;
  logic [7:0]       shift_q, shift_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;   // payload bits already sent
  logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d; // payload bytes accepted
  logic [15:0]      crc_sh_q, crc_sh_d;
  logic [3:0]       crc_cnt_q, crc_cnt_d;
  logic             done_q, done_d;

  logic        accept;
  logic        start_acc;
  logic        byte_boundary;
  logic        last_bit;
  logic [15:0] crc;

  assign busy          = (state_q != StIdle);
  assign in_if.ready   = busy & ~pf_full_q & (byte_cnt_q < ByteMax);
  assign accept        = in_if.valid & in_if.ready;
  assign start_acc     = (state_q == StIdle) & start;
  assign byte_boundary = (bit_cnt_q[2:0] == 3'd7);
  assign last_bit      = (bit_cnt_q == LastBit);
  assign done          = done_q;

  sd_dat_block_tx_crc16_acc u_crc (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (start_acc),
    .en    (accept),
    .data  (in_if.data),
    .crc   (crc)
  );

  always_comb begin
    state_d    = state_q;
    pf_d       = pf_q;
    pf_full_d  = pf_full_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    crc_sh_d   = crc_sh_q;
    crc_cnt_d  = crc_cnt_q;
    done_d     = 1'b0;
    hold       = 1'b0;
    sd_dat     = EndBit;
    sd_dat_oe  = 1'b1;

    // Prefetch fill; never coincides with a shifter load since ready needs it empty.
    if (accept) begin
      pf_d       = in_if.data;
      pf_full_d  = 1'b1;
      byte_cnt_d = byte_cnt_q + 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        sd_dat_oe = 1'b0;
        if (start) begin
          state_d    = StStart;
          bit_cnt_d  = '0;
          byte_cnt_d = '0;
          crc_cnt_d  = '0;
          pf_full_d  = 1'b0;
        end
      end
      StStart: begin
        sd_dat = StartBit;
        hold   = ~pf_full_q;
        if (bit_en && pf_full_q) begin
          shift_d   = pf_q;
          pf_full_d = 1'b0;
          state_d   = StData;
        end
      end
      StData: begin
        sd_dat = shift_q[7];
        // Underrun on the last bit of a byte: freeze the line until the next byte lands.
        hold   = byte_boundary & ~last_bit & ~pf_full_q;
        if (bit_en) begin
          if (!byte_boundary) begin
            shift_d   = {shift_q[6:0], 1'b0};
            bit_cnt_d = bit_cnt_q + 1'b1;
          end else if (last_bit) begin
            // All bytes have been folded into the CRC by now.
            crc_sh_d  = crc;
            crc_cnt_d = '0;
            state_d   = StCrc;
          end else if (pf_full_q) begin
            shift_d   = pf_q;
            pf_full_d = 1'b0;
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      StCrc: begin
        sd_dat = crc_sh_q[15];
        if (bit_en) begin
          crc_sh_d  = {crc_sh_q[14:0], 1'b0};
          crc_cnt_d = crc_cnt_q + 4'd1;
          if (crc_cnt_q == 4'd15) state_d = StEnd;
        end
      end
      StEnd: begin
        sd_dat = EndBit;
        if (bit_en) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      pf_q       <= '0;
      pf_full_q  <= 1'b0;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      byte_cnt_q <= '0;
      crc_sh_q   <= '0;
      crc_cnt_q  <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pf_q       <= pf_d;
      pf_full_q  <= pf_full_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      crc_sh_q   <= crc_sh_d;
      crc_cnt_q  <= crc_cnt_d;
      done_q     <= done_d;
    end
  end

endmodule

// File: tb/tb_sd_dat_block_tx.sv
// Directed bench for sd_dat_block_tx at the default 512-byte block size.
module tb_sd_dat_block_tx;

  localparam int NBits = 1 + 8 * 512 + 16 + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic bit_en = 1'b0;
  logic sd_dat, sd_dat_oe, hold, busy, done;

  sd_dat_block_tx_if in_if ();

  sd_dat_block_tx #(
    .BLOCK_BYTES (512),
    .CNT_W       (13)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .bit_en    (bit_en),
    .in_if     (in_if),
    .sd_dat    (sd_dat),
    .sd_dat_oe (sd_dat_oe),
    .hold      (hold),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // bit_en generator: every cycle when ben_div<=1, else one cycle in ben_div.
  int ben_div = 1;
  int ben_ph = 0;
  always @(posedge clk) begin
    #2;
    if (ben_div <= 1) begin
      bit_en = 1'b1;
    end else begin
      ben_ph = (ben_ph + 1) % ben_div;
      bit_en = (ben_ph == 0);
    end
  end

  // Line monitor: samples what the next rising edge will act on.
  logic clr = 1'b0;
  logic bits [0:4199];
  int   nbits, acc_cnt, done_cnt, nb_at_done, busy_cyc, frozen_err, hold_bad;
  logic hold_seen, prev_hold, prev_dat;

  always @(negedge clk) begin
    #1;
    if (clr) begin
      nbits = 0; acc_cnt = 0; done_cnt = 0; nb_at_done = -1; busy_cyc = 0;
      frozen_err = 0; hold_seen = 1'b0; prev_hold = 1'b0; prev_dat = 1'b1;
    end else begin
      if (in_if.valid && in_if.ready) acc_cnt++;
      if (bit_en && !hold && sd_dat_oe) begin
        if (nbits < 4200) bits[nbits] = sd_dat;
        nbits++;
      end
      if (done) begin
        if (done_cnt == 0) nb_at_done = nbits;
        done_cnt++;
      end
      if (busy) busy_cyc++;
      if (hold) hold_seen = 1'b1;
      if (hold && prev_hold && (sd_dat !== prev_dat)) frozen_err++;
      if (hold && (!sd_dat_oe || nbits > 4096)) hold_bad++;
      prev_hold = hold;
      prev_dat  = sd_dat;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_block(input logic [7:0] b);
    in_if.data  = b;
    in_if.valid = 1'b1;
    @(posedge clk);
    clr = 1'b1;
    @(posedge clk);
    clr = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (done_cnt == 0 && n < 40000) begin
      @(posedge clk);
      n++;
    end
    check({tag, "_done_seen"}, (done_cnt != 0), 1'b1);
    #1;
    check({tag, "_oe_after_done"}, sd_dat_oe, 1'b0);
    repeat (4) @(posedge clk);
  endtask

  task automatic wait_bits(input int target);
    int n;
    n = 0;
    while (nbits < target && n < 40000) begin
      @(posedge clk);
      n++;
    end
    check("wait_bits_reached", (nbits >= target), 1'b1);
  endtask

  task automatic check_block(input string tag, input logic [7:0] b, input logic [15:0] exp_crc);
    int          derr;
    logic [15:0] crc_obs;
    derr = 0;
    crc_obs = '0;
    if (nbits == NBits) begin
      for (int i = 1; i <= 4096; i++) begin
        if (bits[i] !== b[7 - ((i - 1) % 8)]) derr++;
      end
      for (int i = 0; i < 16; i++) crc_obs = {crc_obs[14:0], bits[4097 + i]};
    end
    check({tag, "_nbits"}, nbits, NBits);
    check({tag, "_start_bit"}, bits[0], 1'b0);
    check({tag, "_data_errs"}, derr, 0);
    check({tag, "_crc"}, crc_obs, exp_crc);
    check({tag, "_end_bit"}, bits[NBits - 1], 1'b1);
    check({tag, "_accepted"}, acc_cnt, 512);
    check({tag, "_done_count"}, done_cnt, 1);
    check({tag, "_done_at_bit"}, nb_at_done, NBits);
  endtask

  initial begin
    int n;
    hold_bad = 0;
    in_if.data  = 8'h00;
    in_if.valid = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_dat", sd_dat, 1'b1);
    check("rst_oe", sd_dat_oe, 1'b0);
    check("rst_ready", in_if.ready, 1'b0);
    check("rst_hold", hold, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1: all-ones block, bit_en every cycle
    start_block(8'hFF);
    wait_done("t1");
    check_block("t1", 8'hFF, 16'h7FA1);

    // 2: all-zeros block
    start_block(8'h00);
    wait_done("t2");
    check_block("t2", 8'h00, 16'h0000);

    // 3: producer stalls after byte 10
    start_block(8'hFF);
    n = 0;
    while (acc_cnt < 10 && n < 1000) begin
      @(posedge clk);
      n++;
    end
    @(negedge clk);
    in_if.valid = 1'b0;
    repeat (20) @(negedge clk);
    in_if.valid = 1'b1;
    wait_done("t3");
    check_block("t3", 8'hFF, 16'h7FA1);
    check("t3_hold_seen", hold_seen, 1'b1);
    check("t3_frozen_errs", frozen_err, 0);

    // 4: bit_en every 4th cycle
    ben_div = 4;
    start_block(8'hFF);
    wait_done("t4");
    check_block("t4", 8'hFF, 16'h7FA1);
    check("t4_duration_ok", (busy_cyc >= 4 * (NBits - 1)) && (busy_cyc <= 4 * NBits + 8), 1'b1);
    ben_div = 1;

    // 5: reset during the CRC field, then a clean block
    start_block(8'hFF);
    wait_bits(4100);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t5_rst_oe", sd_dat_oe, 1'b0);
    check("t5_rst_dat", sd_dat, 1'b1);
    check("t5_rst_busy", busy, 1'b0);
    check("t5_rst_ready", in_if.ready, 1'b0);
    repeat (5) @(negedge clk);
    check("t5_no_done", done_cnt, 0);
    rst_n = 1'b1;
    @(negedge clk);
    start_block(8'hFF);
    wait_done("t5b");
    check_block("t5b", 8'hFF, 16'h7FA1);

    // 6: start pulsed mid-block, producer keeps offering bytes
    start_block(8'hFF);
    wait_bits(100);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("t6");
    check_block("t6", 8'hFF, 16'h7FA1);
    repeat (30) @(negedge clk);
    check("t6_single_done", done_cnt, 1);
    check("t6_no_513th", acc_cnt, 512);
    check("t6_idle", busy, 1'b0);

    check("hold_outside_payload", hold_bad, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
